// File: rtl/fsm_seq_checker.sv
// fsm_seq_checker
//   Receive-side self-checker for a 3-bit counting producer (state 0..7 with
//   a carry-out that is high exactly on state 7). It locks onto a valid count
//   sequence, flags sequence/carry violations while locked, recognises a
//   producer restart, and keeps saturating error and 7->0 wrap counts.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   valid      in   sample enable for state_in / cout_in
//   state_in   in   [2:0] producer state
//   cout_in    in   producer carry-out
//   locked     out  sequence lock indicator
//   err        out  one-cycle pulse on a violation while locked
//   restart    out  one-cycle pulse on a detected producer restart
//   err_count  out  [ERR_W-1:0]  saturating violation count
//   wrap_count out  [WRAP_W-1:0] saturating wrap count (only counted while locked)
//   dbg_state  out  [1:0] current FSM state (0 idle, 1 acquire, 2 locked)
//
// Sample semantics: a sample is taken on a rising edge where valid = 1.
// With valid = 0 nothing but the err/restart pulses changes.
module fsm_seq_checker #(
  parameter int LOCK_LEN = 3,
  parameter int ERR_W    = 8,
  parameter int WRAP_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid,
  input  logic [2:0]        state_in,
  input  logic              cout_in,
  output logic              locked,
  output logic              err,
  output logic              restart,
  output logic [ERR_W-1:0]  err_count,
  output logic [WRAP_W-1:0] wrap_count,
  output logic [1:0]        dbg_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACQ  = 2'd1;
  localparam logic [1:0] S_LOCK = 2'd2;

  localparam logic [2:0] LOCK_TGT = 3'(LOCK_LEN);

  logic [1:0] st;
  logic [2:0] prev;
  logic [2:0] match_cnt;

  logic [2:0] prev_inc;
  logic       correct;
  logic       is_restart;
  logic       is_wrap;
  logic       err_sat;
  logic       wrap_sat;

  always_comb begin
    prev_inc   = prev + 3'd1;
    correct    = (state_in == prev_inc) && (cout_in == (state_in == 3'd7));
    // A return to 0 without carry is a producer reset, unless it is the
    // legitimate 7->0 roll-over (which is a correct transition anyway).
    is_restart = (state_in == 3'd0) && !cout_in && (prev != 3'd7);
    is_wrap    = (prev == 3'd7) && (state_in == 3'd0);
    err_sat    = &err_count;
    wrap_sat   = &wrap_count;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st         <= S_IDLE;
      prev       <= 3'd0;
      match_cnt  <= 3'd0;
      locked     <= 1'b0;
      err        <= 1'b0;
      restart    <= 1'b0;
      err_count  <= '0;
      wrap_count <= '0;
    end else begin
      err     <= 1'b0;
      restart <= 1'b0;
      if (valid) begin
        prev <= state_in;
        case (st)
          S_IDLE: begin
            st        <= S_ACQ;
            match_cnt <= 3'd0;
          end
          S_ACQ: begin
            if (correct) begin
              if (match_cnt + 3'd1 == LOCK_TGT) begin
                st        <= S_LOCK;
                locked    <= 1'b1;
                match_cnt <= 3'd0;
              end else begin
                match_cnt <= match_cnt + 3'd1;
              end
            end else begin
              match_cnt <= 3'd0;
            end
          end
          S_LOCK: begin
            if (correct) begin
              if (is_wrap && !wrap_sat) wrap_count <= wrap_count + WRAP_W'(1);
            end else begin
              // Restart takes priority so a producer held at 0 costs one
              // restart pulse and never an error.
              if (is_restart) begin
                restart <= 1'b1;
              end else begin
                err <= 1'b1;
                if (!err_sat) err_count <= err_count + ERR_W'(1);
              end
              st        <= S_ACQ;
              locked    <= 1'b0;
              match_cnt <= 3'd0;
            end
          end
          default: begin
            st        <= S_IDLE;
            locked    <= 1'b0;
            match_cnt <= 3'd0;
          end
        endcase
      end
    end
  end

  assign dbg_state = st;

endmodule

// File: tb/tb_fsm_seq_checker.sv
// Bench for fsm_seq_checker. Two instances share the same stimulus: u_dut with
// default widths and u_sat with ERR_W = 2 to observe error-count saturation.
// Each driven sample pushes its hand-computed expected outputs
// {locked, err, restart, err_count, wrap_count, sat err_count} into exp_q;
// the monitor pops one entry after every rising edge that follows a push.
module tb_fsm_seq_checker;

  localparam int EW = 1 + 1 + 1 + 8 + 8 + 2;

  logic       clk;
  logic       reset;
  logic       valid;
  logic [2:0] state_in;
  logic       cout_in;

  logic       locked, err, restart;
  logic [7:0] err_count, wrap_count;
  logic [1:0] dbg_state;

  logic       s_locked, s_err, s_restart;
  logic [1:0] s_err_count;
  logic [7:0] s_wrap_count;
  logic [1:0] s_dbg_state;

  logic [EW-1:0] exp_q[$];
  int n_cmp;
  int n_bad;

  fsm_seq_checker #(.LOCK_LEN(3), .ERR_W(8), .WRAP_W(8)) u_dut (
    .clk(clk), .reset(reset), .valid(valid), .state_in(state_in),
    .cout_in(cout_in), .locked(locked), .err(err), .restart(restart),
    .err_count(err_count), .wrap_count(wrap_count), .dbg_state(dbg_state)
  );

  fsm_seq_checker #(.LOCK_LEN(3), .ERR_W(2), .WRAP_W(8)) u_sat (
    .clk(clk), .reset(reset), .valid(valid), .state_in(state_in),
    .cout_in(cout_in), .locked(s_locked), .err(s_err), .restart(s_restart),
    .err_count(s_err_count), .wrap_count(s_wrap_count), .dbg_state(s_dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // driver: one sample per falling edge with its expected registered response
  task automatic s(input logic v, input logic [2:0] st, input logic c,
                   input logic lk, input logic e, input logic r,
                   input logic [7:0] ec, input logic [7:0] wc, input logic [1:0] ec2);
    @(negedge clk);
    valid    = v;
    state_in = st;
    cout_in  = c;
    exp_q.push_back({lk, e, r, ec, wc, ec2});
  endtask

  // monitor / scoreboard
  initial begin
    logic [EW-1:0] want;
    logic [EW-1:0] got;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        got  = {locked, err, restart, err_count, wrap_count, s_err_count};
        n_cmp++;
        if (got !== want) begin
          n_bad++;
          $display("FAIL sample@%0t: got lk=%b err=%b rst=%b ec=%0d wc=%0d sat_ec=%0d expected lk=%b err=%b rst=%b ec=%0d wc=%0d sat_ec=%0d",
                   $time, got[20], got[19], got[18], got[17:10], got[9:2], got[1:0],
                   want[20], want[19], want[18], want[17:10], want[9:2], want[1:0]);
        end
      end
    end
  end

  task automatic chk_all_zero(input string name);
    chk({name, ".locked"},     32'(locked),      32'd0);
    chk({name, ".err"},        32'(err),         32'd0);
    chk({name, ".restart"},    32'(restart),     32'd0);
    chk({name, ".err_count"},  32'(err_count),   32'd0);
    chk({name, ".wrap_count"}, 32'(wrap_count),  32'd0);
    chk({name, ".sat_ec"},     32'(s_err_count), 32'd0);
    chk({name, ".sat_locked"}, 32'(s_locked),    32'd0);
    chk({name, ".dbg_state"},  32'(dbg_state),   32'd0);
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    reset    = 1'b0;
    valid    = 1'b0;
    state_in = 3'd0;
    cout_in  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset_state");
    @(negedge clk);
    reset = 1'b1;

    // 1: lock and wrap
    s(1,0,0, 0,0,0,0,0,0);
    s(1,1,0, 0,0,0,0,0,0);
    s(1,2,0, 0,0,0,0,0,0);
    s(1,3,0, 1,0,0,0,0,0);
    s(1,4,0, 1,0,0,0,0,0);
    s(1,5,0, 1,0,0,0,0,0);
    s(1,6,0, 1,0,0,0,0,0);
    s(1,7,1, 1,0,0,0,0,0);
    s(1,0,0, 1,0,0,0,1,0);
    s(1,1,0, 1,0,0,0,1,0);

    // 2: skip, relock in acquire across 7->0 (no wrap)
    s(1,2,0, 1,0,0,0,1,0);
    s(1,3,0, 1,0,0,0,1,0);
    s(1,5,0, 0,1,0,1,1,1);
    s(1,6,0, 0,0,0,1,1,1);
    s(1,7,1, 0,0,0,1,1,1);
    s(1,0,0, 1,0,0,1,1,1);

    // 3: carry fault on state 7
    for (int i = 1; i <= 6; i++) s(1,3'(i),0, 1,0,0,1,1,1);
    s(1,7,0, 0,1,0,2,1,2);
    s(1,0,0, 0,0,0,2,1,2);
    s(1,1,0, 0,0,0,2,1,2);
    s(1,2,0, 1,0,0,2,1,2);

    // 4: producer restart (held at 0)
    s(1,3,0, 1,0,0,2,1,2);
    s(1,4,0, 1,0,0,2,1,2);
    s(1,0,0, 0,0,1,2,1,2);
    s(1,0,0, 0,0,0,2,1,2);
    s(1,0,0, 0,0,0,2,1,2);
    s(1,1,0, 0,0,0,2,1,2);
    s(1,2,0, 0,0,0,2,1,2);
    s(1,3,0, 1,0,0,2,1,2);

    // 5: valid gaps carrying garbage
    s(0,6,1, 1,0,0,2,1,2);
    s(1,4,0, 1,0,0,2,1,2);
    s(0,0,1, 1,0,0,2,1,2);
    s(0,2,0, 1,0,0,2,1,2);
    s(1,5,0, 1,0,0,2,1,2);
    s(0,7,0, 1,0,0,2,1,2);
    s(1,6,0, 1,0,0,2,1,2);
    s(1,7,1, 1,0,0,2,1,2);
    s(0,3,1, 1,0,0,2,1,2);
    s(1,0,0, 1,0,0,2,2,2);
    s(1,1,0, 1,0,0,2,2,2);

    // more violations: skip, hold, cout on non-7; ERR_W=2 instance saturates at 3
    s(1,3,0, 0,1,0,3,2,3);
    s(1,4,0, 0,0,0,3,2,3);
    s(1,5,0, 0,0,0,3,2,3);
    s(1,6,0, 1,0,0,3,2,3);
    s(1,6,0, 0,1,0,4,2,3);
    s(1,7,1, 0,0,0,4,2,3);
    s(1,0,0, 0,0,0,4,2,3);
    s(1,1,0, 1,0,0,4,2,3);
    s(1,2,1, 0,1,0,5,2,3);
    s(1,3,0, 0,0,0,5,2,3);
    s(1,4,0, 0,0,0,5,2,3);
    s(1,5,0, 1,0,0,5,2,3);
    s(0,0,0, 1,0,0,5,2,3);

    // 6: async reset between edges while locked with err_count = 5
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk_all_zero("async_reset");
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset_hold");
    @(negedge clk);
    reset = 1'b1;
    s(1,5,0, 0,0,0,0,0,0);
    s(1,6,0, 0,0,0,0,0,0);
    s(1,7,1, 0,0,0,0,0,0);
    s(1,0,0, 1,0,0,0,0,0);
    s(1,1,0, 1,0,0,0,0,0);
    @(negedge clk);
    valid = 1'b0;

    // drain with a bounded wait
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
